// File: rtl/load_unit.sv
// ----------------------------------------------------------------------------
// load_unit
//   Multi-cycle data-memory load stage for the 64-bit core. Takes a load
//   command from execute and issues one valid/ready request to data memory.
//   It captures the returned doubleword and extracts the addressed
//   byte/half/word/double, then sign- or zero-extends it. The result is held
//   for the write-back result-source select.
//
//   Optional build macro: LOAD_MISALIGN_CHECK_EN
//     defined   : misaligned loads skip memory and complete with o_misaligned=1,
//                 o_load_data=0
//     undefined : o_misaligned tied low; misaligned offsets are forced to
//                 natural alignment
//
// Ports:
//   clk          clock, rising edge
//   arst         asynchronous active-high reset
//   i_start      load command strobe (sampled only in IDLE)
//   i_addr       byte address of the load
//   i_funct3     load type (LB/LH/LW/LD/LBU/LHU/LWU, 111 = LD)
//   o_mem_req    memory request valid
//   o_mem_addr   doubleword-aligned memory address
//   i_mem_ready  memory accepts the request
//   i_mem_rvalid read data valid
//   i_mem_rdata  read doubleword, little-endian
//   o_busy       high whenever the FSM is not IDLE
//   o_load_valid one-cycle pulse, o_load_data newly updated
//   o_load_data  extended load result, held between loads
//   o_misaligned one-cycle misaligned-address pulse
// ----------------------------------------------------------------------------
module load_unit #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]            i_funct3,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   input  logic                  i_mem_ready,
   input  logic                  i_mem_rvalid,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic                  o_busy,
   output logic                  o_load_valid,
   output logic [DATA_WIDTH-1:0] o_load_data,
   output logic                  o_misaligned
);

   localparam int unsigned OFF_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [2:0]            r_funct3;
   logic                  r_mem_req;
   logic                  r_busy;
   logic                  r_load_valid;
   logic [DATA_WIDTH-1:0] r_load_data;

   logic                  w_latch;
   logic [DATA_WIDTH-1:0] w_data_d;
   logic [OFF_W-1:0]      w_off;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_ext;

`ifdef LOAD_MISALIGN_CHECK_EN
   logic r_misaligned;
   logic w_mis_d;
   logic w_mis_c;

   // Misalignment test on the incoming command (size from funct3[1:0])
   always_comb begin
      w_mis_c = 1'b0;
      case (i_funct3[1:0])
         2'b01:   w_mis_c = i_addr[0];
         2'b10:   w_mis_c = |i_addr[1:0];
         2'b11:   w_mis_c = |i_addr[2:0];
         default: w_mis_c = 1'b0;
      endcase
   end
`endif

   // Byte offset forced to natural alignment for the access size
   always_comb begin
      w_off = r_addr[OFF_W-1:0];
      case (r_funct3[1:0])
         2'b00:   w_off = r_addr[OFF_W-1:0];
         2'b01:   w_off[0] = 1'b0;
         2'b10:   w_off[1:0] = 2'b00;
         default: w_off = 3'b000;
      endcase
   end

   assign w_shifted = i_mem_rdata >> {w_off, 3'b000};

   // Field extraction with sign/zero extension
   always_comb begin
      case (r_funct3)
         3'b000:  w_ext = {{(DATA_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
         3'b001:  w_ext = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
         3'b010:  w_ext = {{(DATA_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
         3'b100:  w_ext = {{(DATA_WIDTH-8){1'b0}},  w_shifted[7:0]};
         3'b101:  w_ext = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
         3'b110:  w_ext = {{(DATA_WIDTH-32){1'b0}}, w_shifted[31:0]};
         default: w_ext = w_shifted;
      endcase
   end

   // Next-state and next-output decode
   always_comb begin
      w_next   = r_state;
      w_latch  = 1'b0;
      w_data_d = r_load_data;
`ifdef LOAD_MISALIGN_CHECK_EN
      w_mis_d  = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_latch = 1'b1;
`ifdef LOAD_MISALIGN_CHECK_EN
               if (w_mis_c) begin
                  w_next   = S_DONE;
                  w_mis_d  = 1'b1;
                  w_data_d = '0;
               end else begin
                  w_next = S_REQ;
               end
`else
               w_next = S_REQ;
`endif
            end
         end
         S_REQ: begin
            if (i_mem_ready) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (i_mem_rvalid) begin
               w_next   = S_DONE;
               w_data_d = w_ext;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State, command latch and registered outputs (decoded from next state)
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state      <= S_IDLE;
         r_addr       <= '0;
         r_funct3     <= '0;
         r_mem_req    <= 1'b0;
         r_busy       <= 1'b0;
         r_load_valid <= 1'b0;
         r_load_data  <= '0;
`ifdef LOAD_MISALIGN_CHECK_EN
         r_misaligned <= 1'b0;
`endif
      end else begin
         r_state      <= w_next;
         r_mem_req    <= (w_next == S_REQ);
         r_busy       <= (w_next != S_IDLE);
         r_load_valid <= (w_next == S_DONE);
         r_load_data  <= w_data_d;
`ifdef LOAD_MISALIGN_CHECK_EN
         r_misaligned <= w_mis_d;
`endif
         if (w_latch) begin
            r_addr   <= i_addr;
            r_funct3 <= i_funct3;
         end
      end
   end

   assign o_mem_req    = r_mem_req;
   assign o_mem_addr   = {r_addr[ADDR_WIDTH-1:OFF_W], 3'b000};
   assign o_busy       = r_busy;
   assign o_load_valid = r_load_valid;
   assign o_load_data  = r_load_data;
`ifdef LOAD_MISALIGN_CHECK_EN
   assign o_misaligned = r_misaligned;
`else
   assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_unit.sv
// ----------------------------------------------------------------------------
// tb_load_unit
//   Directed bench for load_unit. The stimulus thread acts as the execute
//   stage and the data memory; every issued load pushes its expected result
//   into a scoreboard queue that a negedge monitor pops on each o_load_valid.
// ----------------------------------------------------------------------------
module tb_load_unit;

   logic        clk;
   logic        arst;
   logic        i_start;
   logic [63:0] i_addr;
   logic [2:0]  i_funct3;
   logic        o_mem_req;
   logic [63:0] o_mem_addr;
   logic        i_mem_ready;
   logic        i_mem_rvalid;
   logic [63:0] i_mem_rdata;
   logic        o_busy;
   logic        o_load_valid;
   logic [63:0] o_load_data;
   logic        o_misaligned;

   typedef struct {
      logic [63:0] data;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   load_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
      .clk          (clk),
      .arst         (arst),
      .i_start      (i_start),
      .i_addr       (i_addr),
      .i_funct3     (i_funct3),
      .o_mem_req    (o_mem_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_ready  (i_mem_ready),
      .i_mem_rvalid (i_mem_rvalid),
      .i_mem_rdata  (i_mem_rdata),
      .o_busy       (o_busy),
      .o_load_valid (o_load_valid),
      .o_load_data  (o_load_data),
      .o_misaligned (o_misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every result pulse must match the oldest expectation
   always @(negedge clk) begin
      if (!arst && o_load_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got data %h with empty queue at %0t", o_load_data, $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_data", o_load_data, e.data);
            check("sb_misaligned", 64'(o_misaligned), 64'(e.mis));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (o_busy && k < 20) begin
         step();
         k++;
      end
      check("idle_before_start", 64'(o_busy), 64'd0);
   endtask

   // One complete load: request, optional backpressure, optional slow response
   task automatic do_load(input logic [63:0] addr, input logic [2:0] f3,
                          input logic [63:0] rdata, input int rdy_dly,
                          input int rv_dly, input logic [63:0] exp_data,
                          input bit poke_start);
      exp_t e;
      logic [63:0] exp_maddr;
      exp_maddr = {addr[63:3], 3'b000};
      wait_idle();
      i_start  = 1'b1;
      i_addr   = addr;
      i_funct3 = f3;
      step();
      i_start  = 1'b0;
      i_addr   = 64'hFFFF_FFFF_FFFF_FFF8;
      check("req_asserted", 64'(o_mem_req), 64'd1);
      check("req_addr", o_mem_addr, exp_maddr);
      for (int i = 0; i < rdy_dly; i++) begin
         step();
         check("req_held", 64'(o_mem_req), 64'd1);
         check("req_addr_stable", o_mem_addr, exp_maddr);
      end
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      check("req_dropped", 64'(o_mem_req), 64'd0);
      check("busy_wait", 64'(o_busy), 64'd1);
      for (int i = 0; i < rv_dly; i++) begin
         if (poke_start && i == 1) begin
            i_start  = 1'b1;
            i_addr   = 64'h6000;
            i_funct3 = 3'b011;
         end
         step();
         i_start = 1'b0;
         check("no_req_in_wait", 64'(o_mem_req), 64'd0);
         check("busy_wait", 64'(o_busy), 64'd1);
      end
      e.data = exp_data;
      e.mis  = 1'b0;
      sb_q.push_back(e);
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = rdata;
      step();
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = 64'hA5A5_5A5A_C3C3_3C3C;
      check("valid_pulse", 64'(o_load_valid), 64'd1);
      check("busy_done", 64'(o_busy), 64'd1);
      step();
      check("valid_one_cycle", 64'(o_load_valid), 64'd0);
      check("idle_after_done", 64'(o_busy), 64'd0);
      check("no_second_req", 64'(o_mem_req), 64'd0);
   endtask

   initial begin
      arst         = 1'b1;
      i_start      = 1'b0;
      i_addr       = '0;
      i_funct3     = '0;
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      repeat (3) step();
      check("rst_req", 64'(o_mem_req), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_valid", 64'(o_load_valid), 64'd0);
      check("rst_data", o_load_data, 64'd0);
      check("rst_mis", 64'(o_misaligned), 64'd0);
      arst = 1'b0;
      step();

      // LB sign extension, zero-wait memory (valid at N+3)
      do_load(64'h1005, 3'b000, 64'h0011_8000_0000_0000, 0, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      // LWU with 3 cycles of backpressure
      do_load(64'h2004, 3'b110, 64'h8765_4321_DEAD_BEEF, 3, 0, 64'h0000_0000_8765_4321, 1'b0);
      // LD with slow response
      do_load(64'h3000, 3'b011, 64'h0123_4567_89AB_CDEF, 0, 5, 64'h0123_4567_89AB_CDEF, 1'b0);
      // LH with an ignored start pulse during WAIT
      do_load(64'h5006, 3'b001, 64'h8001_0000_0000_0000, 0, 3, 64'hFFFF_FFFF_FFFF_8001, 1'b1);
      // LHU
      do_load(64'h5002, 3'b101, 64'h0000_0000_F00D_0000, 1, 1, 64'h0000_0000_0000_F00D, 1'b0);
      // LBU top byte
      do_load(64'h7007, 3'b100, 64'hA500_0000_0000_0000, 0, 0, 64'h0000_0000_0000_00A5, 1'b0);
      // LW sign extension, upper word
      do_load(64'h7004, 3'b010, 64'h8000_0001_0000_0000, 0, 1, 64'hFFFF_FFFF_8000_0001, 1'b0);
      // funct3 111 behaves as LD
      do_load(64'h7000, 3'b111, 64'hFEDC_BA98_7654_3210, 0, 0, 64'hFEDC_BA98_7654_3210, 1'b0);

      // Misaligned LW at 0x4002
`ifdef LOAD_MISALIGN_CHECK_EN
      begin
         exp_t e;
         wait_idle();
         e.data = 64'd0;
         e.mis  = 1'b1;
         sb_q.push_back(e);
         i_start  = 1'b1;
         i_addr   = 64'h4002;
         i_funct3 = 3'b010;
         step();
         i_start = 1'b0;
         check("mis_no_req", 64'(o_mem_req), 64'd0);
         check("mis_valid", 64'(o_load_valid), 64'd1);
         check("mis_flag", 64'(o_misaligned), 64'd1);
         check("mis_data", o_load_data, 64'd0);
         step();
         check("mis_one_cycle", 64'(o_misaligned), 64'd0);
         check("mis_idle", 64'(o_busy), 64'd0);
      end
`else
      do_load(64'h4002, 3'b010, 64'h1122_3344_8899_AABB, 0, 0, 64'hFFFF_FFFF_8899_AABB, 1'b0);
`endif

      // Reset during REQ drops the request immediately
      wait_idle();
      i_start  = 1'b1;
      i_addr   = 64'h8000;
      i_funct3 = 3'b011;
      step();
      i_start = 1'b0;
      check("pre_rst_req", 64'(o_mem_req), 64'd1);
      arst = 1'b1;
      #1;
      check("rst_req_immediate", 64'(o_mem_req), 64'd0);
      check("rst_req_busy", 64'(o_busy), 64'd0);
      step();
      arst = 1'b0;

      // Reload some data, then reset mid-WAIT and drop the late response
      do_load(64'h9000, 3'b011, 64'h1357_9BDF_2468_ACE0, 0, 0, 64'h1357_9BDF_2468_ACE0, 1'b0);
      i_start  = 1'b1;
      i_addr   = 64'hA000;
      i_funct3 = 3'b011;
      step();
      i_start     = 1'b0;
      i_mem_ready = 1'b1;
      step();
      i_mem_ready = 1'b0;
      check("pre_rst_wait_busy", 64'(o_busy), 64'd1);
      arst = 1'b1;
      #1;
      check("rstw_req", 64'(o_mem_req), 64'd0);
      check("rstw_busy", 64'(o_busy), 64'd0);
      check("rstw_data", o_load_data, 64'd0);
      step();
      arst         = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 64'hFFFF_0000_FFFF_0000;
      step();
      i_mem_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rstw_no_valid", 64'(o_load_valid), 64'd0);
         check("rstw_idle", 64'(o_busy), 64'd0);
         step();
      end
      check("rstw_data_kept", o_load_data, 64'd0);

      step();
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Multi-cycle data-memory load stage for the 64-bit core.
- Accepts a load command from the execute stage and performs a valid/ready request to data memory.
- Captures the returned doubleword, then extracts and sign/zero-extends the addressed byte, half, word or double.
- Holds the result as the memory-data input of the write-back result-source select; o_busy stalls the pipeline while a load is in flight.

Parameters:
- DATA_WIDTH, 64: memory data and result width; fixed at 64, other values unsupported.
- ADDR_WIDTH, 64: byte address width.

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  asynchronous active-high reset.
- i_start  input  1  load command strobe; sampled only in IDLE.
- i_addr  input  ADDR_WIDTH  byte address of the load.
- i_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 treated as LD.
- o_mem_req  output  1  memory request valid.
- o_mem_addr  output  ADDR_WIDTH  doubleword-aligned address, {addr[ADDR_WIDTH-1:3], 3'b000}.
- i_mem_ready  input  1  memory accepts the request.
- i_mem_rvalid  input  1  read data valid.
- i_mem_rdata  input  DATA_WIDTH  read doubleword, little-endian.
- o_busy  output  1  high in any state other than IDLE.
- o_load_valid  output  1  one-cycle pulse: o_load_data is newly updated.
- o_load_data  output  DATA_WIDTH  extended load result; holds its value between loads.
- o_misaligned  output  1  one-cycle misaligned-address pulse (optional feature).

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE; all outputs and latched address/funct3 go to 0. o_mem_req drops immediately when arst asserts, mid-transaction included. A pending memory response after reset is ignored because rvalid is sampled only in WAIT.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - i_start=1: latch i_addr and i_funct3, go to REQ.
  - i_start is ignored in every other state; no queueing.
- REQ:
  - o_mem_req=1; o_mem_addr driven from the latched address and held stable until handshake.
  - Handshake is o_mem_req & i_mem_ready on a rising edge; then go to WAIT.
  - i_mem_rvalid is ignored in REQ.
- WAIT:
  - o_mem_req=0; wait indefinitely for i_mem_rvalid.
  - On i_mem_rvalid: off = addr[2:0], bit offset = off*8.
  - Extract the field from i_mem_rdata at that offset:
    - B: 8 bits; H: 16 bits; W: 32 bits; D: all 64 bits (off ignored).
    - LB/LH/LW sign-extend to 64 bits.
    - LBU/LHU/LWU zero-extend to 64 bits.
  - Register the result into o_load_data; go to DONE.
- DONE: o_load_valid=1 for exactly one cycle; return to IDLE. A new i_start is accepted on the following cycle (IDLE).
- Minimum latency: i_start at cycle N, req at N+1, ready at N+1, rvalid at N+2, o_load_valid at N+3. Back-to-back loads issue every 4 cycles minimum.
- o_busy=1 in REQ, WAIT and DONE.

Optional Feature:
- Macro: LOAD_MISALIGN_CHECK_EN.
- Defined:
  - In IDLE, a load with i_start=1 is misaligned if: H and addr[0]≠0, W and addr[1:0]≠0, or D/111 and addr[2:0]≠0.
  - A misaligned load makes no memory request. The FSM goes directly to DONE.
  - In DONE: o_misaligned=1 and o_load_valid=1 for one cycle, o_load_data=0.
- Undefined:
  - o_misaligned is tied to 0.
  - Misaligned offsets are forced to natural alignment by clearing low bits: H clears off[0], W clears off[1:0], D uses offset 0.

Test Plan:
- Reset mid-WAIT: assert arst during WAIT -> o_mem_req=0, o_busy=0, o_load_data=0; a following rvalid produces no o_load_valid.
- LB sign extension: addr=0x1005, rdata=0x0011_8000_0000_0000 -> o_load_data=0xFFFF_FFFF_FFFF_FF80, o_load_valid exactly one cycle, at N+3 with zero-wait memory.
- LWU with backpressure: addr=0x2004, rdata=0x8765_4321_xxxx_xxxx, i_mem_ready low for 3 cycles -> o_mem_addr=0x2000 held stable throughout, o_load_data=0x0000_0000_8765_4321.
- LD with slow response: addr=0x3000, rvalid 5 cycles after handshake -> o_load_data=rdata, o_busy high until DONE.
- Ignored start: i_start pulsed during WAIT with a different address -> no second request; the first load's data is returned.
- LOAD_MISALIGN_CHECK_EN defined: LW at 0x4002 -> no o_mem_req, o_misaligned=1 and o_load_valid=1 at N+1, o_load_data=0. Undefined: same stimulus -> word at offset 0 returned, o_misaligned=0.
